toaplan2_prog_loader: RTL

- Sequencer between the IOCTL byte stream and the SDRAM programming port for the Toaplan2 cores.
- Decodes each byte into a region: game byte, CPU program, sound program or tiles.
- Packs byte pairs into 16-bit word writes, issues PROG_WE with a PROG_RDY handshake, and back-pressures the loader through IOCTL_WAIT.
- Replaces the per-byte masked write path, halving SDRAM programming traffic.

---
 rtl/toaplan2_loader_pkg.sv | 35 +++
 rtl/toaplan2_region_decode.sv | 38 +++
 rtl/toaplan2_prog_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/toaplan2_loader_pkg.sv
// Shared types and constants for the Toaplan2 program loader.
// Optional build macro used by the loader: TOAPLAN2_LOADER_CHECKSUM_EN.
package toaplan2_loader_pkg;

  // Where a download byte belongs
  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_GAME,
    RGN_CPU,
    RGN_SND,
    RGN_TILE
  } region_e;

  // Write sequencer states
  typedef enum logic [1:0] {
    IDLE,
    HALF,
    WRITE
  } state_e;

  // SDRAM byte masks, 1 = lane suppressed, bit1 = [15:8]
  localparam logic [1:0] MASK_FULL = 2'b00;
  localparam logic [1:0] MASK_LOW  = 2'b10;
  localparam logic [1:0] MASK_HIGH = 2'b01;

  // Game IDs carried in download byte 0
  localparam logic [7:0] GAME_TEKIPAKI = 8'd4;
  localparam logic [7:0] GAME_WHOOPEE  = 8'd5;

  // Tiles live in their own bank; CPU and sound share bank 0
  function automatic logic [1:0] region_bank(input region_e r, input logic [1:0] tile_ba);
    return (r == RGN_TILE) ? tile_ba : 2'd0;
  endfunction

endpackage

// File: rtl/toaplan2_region_decode.sv
// Combinational decode of a download byte address into a region and the
// byte offset from the start of that region.
module toaplan2_region_decode
  import toaplan2_loader_pkg::*;
#(
  parameter logic [24:0] CPU_LEN  = 25'h20000,
  parameter logic [24:0] SND_LEN  = 25'h8000,
  parameter logic [24:0] TILE_LEN = 25'h100000
) (
  input  logic [25:0] addr,
  output region_e     region,
  output logic [25:0] rel
);

  localparam logic [25:0] CPU_START  = 26'd1;
  localparam logic [25:0] SND_START  = CPU_START + {1'b0, CPU_LEN};
  localparam logic [25:0] TILE_START = SND_START + {1'b0, SND_LEN};
  localparam logic [25:0] TILE_END   = TILE_START + {1'b0, TILE_LEN};

  // Regions are laid out back to back after the game byte at address 0
  always_comb begin
    region = RGN_NONE;
    rel    = '0;
    if (addr == 26'd0) begin
      region = RGN_GAME;
    end else if (addr < SND_START) begin
      region = RGN_CPU;
      rel    = addr - CPU_START;
    end else if (addr < TILE_START) begin
      region = RGN_SND;
      rel    = addr - SND_START;
    end else if (addr < TILE_END) begin
      region = RGN_TILE;
      rel    = addr - TILE_START;
    end
  end

endmodule

// File: rtl/toaplan2_prog_loader.sv
// Toaplan2 download sequencer: packs IOCTL byte pairs into 16-bit SDRAM
// word writes with a PROG_WE/PROG_RDY handshake and back-pressure.
// Optional build macro: TOAPLAN2_LOADER_CHECKSUM_EN adds a running byte sum
// on CHECKSUM; without it CHECKSUM is tied to zero.
module toaplan2_prog_loader
  import toaplan2_loader_pkg::*;
#(
  parameter logic [24:0] CPU_LEN  = 25'h20000,
  parameter logic [24:0] SND_LEN  = 25'h8000,
  parameter logic [24:0] TILE_LEN = 25'h100000,
  parameter logic [21:0] SND_OFFS = 22'h80000,
  parameter logic [1:0]  TILE_BA  = 2'd1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DOWNLOADING,
  input  logic [25:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  input  logic        IOCTL_WR,
  input  logic        IOCTL_RAM,
  output logic        IOCTL_WAIT,
  output logic [21:0] PROG_ADDR,
  output logic [15:0] PROG_DATA,
  output logic [1:0]  PROG_MASK,
  output logic [1:0]  PROG_BA,
  output logic        PROG_WE,
  input  logic        PROG_RDY,
  output logic [7:0]  GAME,
  output logic        ERR,
  output logic [15:0] CHECKSUM
);

  state_e      state_q, state_d;
  region_e     pend_region_q, pend_region_d;
  logic [21:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        skid_valid_q, skid_valid_d;
  logic [25:0] skid_addr_q, skid_addr_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic        prog_we_q, prog_we_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic [1:0]  prog_ba_q, prog_ba_d;
  logic [7:0]  game_q, game_d;
  logic        err_q, err_d;

  region_e     dec_region;
  logic [25:0] dec_rel;
  logic [25:0] dec_addr;
  logic [25:0] word_full;
  logic [21:0] dec_word;
  logic [1:0]  dec_ba;
  logic [7:0]  byte_data;
  logic        wait_now;
  logic        strobe;
  logic        accept;
  logic        replay;
  logic [3:0]  word_hi_unused;

  // A held skid byte owns the decoder; new strobes are blocked meanwhile
  assign dec_addr  = skid_valid_q ? skid_addr_q : IOCTL_ADDR;
  assign byte_data = skid_valid_q ? skid_data_q : IOCTL_DOUT;

  toaplan2_region_decode #(
    .CPU_LEN  (CPU_LEN),
    .SND_LEN  (SND_LEN),
    .TILE_LEN (TILE_LEN)
  ) u_decode (
    .addr   (dec_addr),
    .region (dec_region),
    .rel    (dec_rel)
  );

  // Word address is formed at full width and truncated to the SDRAM port
  always_comb begin
    word_full = {1'b0, dec_rel[25:1]};
    if (dec_region == RGN_SND) begin
      word_full = word_full + {4'b0000, SND_OFFS};
    end
  end

  assign dec_word       = word_full[21:0];
  assign word_hi_unused = word_full[25:22];
  assign dec_ba         = region_bank(dec_region, TILE_BA);

  assign wait_now = (state_q == WRITE) || skid_valid_q;
  assign strobe   = IOCTL_WR && DOWNLOADING && !IOCTL_RAM;
  assign accept   = strobe && !wait_now;
  assign replay   = (state_q == IDLE) && skid_valid_q;

  // Sequencer: pair bytes into words, flush lone halves, hold the handshake
  always_comb begin
    state_d       = state_q;
    pend_region_d = pend_region_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    skid_valid_d  = skid_valid_q;
    skid_addr_d   = skid_addr_q;
    skid_data_d   = skid_data_q;
    prog_we_d     = prog_we_q;
    prog_addr_d   = prog_addr_q;
    prog_data_d   = prog_data_q;
    prog_mask_d   = prog_mask_q;
    prog_ba_d     = prog_ba_q;
    game_d        = game_q;
    err_d         = err_q | (strobe && wait_now);

    case (state_q)
      IDLE: begin
        if (accept || replay) begin
          skid_valid_d = 1'b0;
          case (dec_region)
            RGN_GAME: game_d = byte_data;
            RGN_CPU, RGN_SND, RGN_TILE: begin
              if (!dec_rel[0]) begin
                pend_region_d = dec_region;
                pend_addr_d   = dec_word;
                pend_data_d   = byte_data;
                state_d       = HALF;
              end else begin
                prog_we_d   = 1'b1;
                prog_addr_d = dec_word;
                prog_data_d = {byte_data, 8'h00};
                prog_mask_d = MASK_HIGH;
                prog_ba_d   = dec_ba;
                state_d     = WRITE;
              end
            end
            default: ;
          endcase
        end
      end

      HALF: begin
        if (!DOWNLOADING) begin
          prog_we_d   = 1'b1;
          prog_addr_d = pend_addr_q;
          prog_data_d = {8'h00, pend_data_q};
          prog_mask_d = MASK_LOW;
          prog_ba_d   = region_bank(pend_region_q, TILE_BA);
          state_d     = WRITE;
        end else if (accept) begin
          case (dec_region)
            RGN_GAME: game_d = byte_data;
            RGN_CPU, RGN_SND, RGN_TILE: begin
              prog_we_d = 1'b1;
              prog_ba_d = region_bank(pend_region_q, TILE_BA);
              state_d   = WRITE;
              if (dec_region == pend_region_q && dec_word == pend_addr_q && dec_rel[0]) begin
                prog_addr_d = pend_addr_q;
                prog_data_d = {byte_data, pend_data_q};
                prog_mask_d = MASK_FULL;
              end else begin
                prog_addr_d  = pend_addr_q;
                prog_data_d  = {8'h00, pend_data_q};
                prog_mask_d  = MASK_LOW;
                skid_valid_d = 1'b1;
                skid_addr_d  = IOCTL_ADDR;
                skid_data_d  = IOCTL_DOUT;
              end
            end
            default: ;
          endcase
        end
      end

      WRITE: begin
        if (PROG_RDY) begin
          prog_we_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops PROG_WE and discards pending data
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      pend_region_q <= RGN_NONE;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_addr_q   <= '0;
      skid_data_q   <= '0;
      prog_we_q     <= 1'b0;
      prog_addr_q   <= '0;
      prog_data_q   <= '0;
      prog_mask_q   <= '0;
      prog_ba_q     <= '0;
      game_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_region_q <= pend_region_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_addr_q   <= skid_addr_d;
      skid_data_q   <= skid_data_d;
      prog_we_q     <= prog_we_d;
      prog_addr_q   <= prog_addr_d;
      prog_data_q   <= prog_data_d;
      prog_mask_q   <= prog_mask_d;
      prog_ba_q     <= prog_ba_d;
      game_q        <= game_d;
      err_q         <= err_d;
    end
  end

  assign IOCTL_WAIT = wait_now;
  assign PROG_WE    = prog_we_q;
  assign PROG_ADDR  = prog_addr_q;
  assign PROG_DATA  = prog_data_q;
  assign PROG_MASK  = prog_mask_q;
  assign PROG_BA    = prog_ba_q;
  assign GAME       = game_q;
  assign ERR        = err_q;

`ifdef TOAPLAN2_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  logic        dl_q, dl_d;

  // Sum the unmasked lanes of each accepted write; restart on a new download
  always_comb begin
    checksum_d = checksum_q;
    dl_d       = DOWNLOADING;
    if (DOWNLOADING && !dl_q) begin
      checksum_d = '0;
    end else if (state_q == WRITE && PROG_RDY) begin
      if (!prog_mask_q[0]) checksum_d = checksum_d + {8'h00, prog_data_q[7:0]};
      if (!prog_mask_q[1]) checksum_d = checksum_d + {8'h00, prog_data_q[15:8]};
    end
  end

  // Checksum and download-edge registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      checksum_q <= '0;
      dl_q       <= 1'b0;
    end else begin
      checksum_q <= checksum_d;
      dl_q       <= dl_d;
    end
  end

  assign CHECKSUM = checksum_q;
`else
  assign CHECKSUM = 16'h0000;
`endif

endmodule
